// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared types and GF(2^8) helpers for the AES MixColumns round stage.
//   aes_state_t is indexed [row][col], the same layout shift_rows produces.
//   Coefficient words are indexed by rotation distance k: output row r takes
//   coef[k] * a_(r+k) summed (XOR) over k = 0..3.
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0]           aes_byte_t;
  typedef aes_byte_t [3:0]      aes_col_t;
  typedef aes_byte_t [3:0][3:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_t;

  // Low byte of the reduction polynomial x^8 + x^4 + x^3 + x + 1.
  localparam aes_byte_t AES_POLY = 8'h1B;

  // Element 0 holds the coefficient of a_r, element 1 that of a_(r+1), ...
  localparam aes_col_t FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
  localparam aes_col_t INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant coefficient synthesis folds this
  // down to a handful of xtime stages and XORs.
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t c);
    aes_byte_t acc;
    aes_byte_t p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// ---------------------------------------------------------------------------
// mix_column_word
//   Combinational MixColumns (INVERSE=0) or InvMixColumns (INVERSE=1) of one
//   4-byte state column.
//   col_in  : column bytes, element r = row r
//   col_out : transformed column, element r = row r
// ---------------------------------------------------------------------------
module mix_column_word
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  aes_col_t col_in,
  output aes_col_t col_out
);

  localparam aes_col_t COEF = INVERSE ? INV_COEF : FWD_COEF;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path through
    // this block leaves a bit unassigned and no latch is inferred.
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        col_out[r] = col_out[r] ^ gf_mul(col_in[2'(r + k)], COEF[k]);
      end
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// ---------------------------------------------------------------------------
// mix_columns_seq
//   Iterative MixColumns / InvMixColumns stage between shift_rows and
//   AddRoundKey. Accepts one state per in_valid/in_ready handshake, transforms
//   COLS_PER_CYCLE columns per clock, and offers the result on
//   out_valid/out_ready. A block captured with in_bypass=1 is passed through
//   untouched (final AES round) and is offered right after the accept edge.
//
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous abort, drops the held block (mc_out keeps value)
//   mc_in       : input state [row][col]
//   in_bypass   : captured with mc_in, 1 = no transform
//   in_valid    : upstream offers a state
//   in_ready    : high only in IDLE
//   mc_out      : result state [row][col], loaded only with a finished block
//   out_valid   : high in DONE until out_ready is seen
//   out_ready   : downstream accepts
// ---------------------------------------------------------------------------
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter bit INVERSE        = 1'b0,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  aes_state_t mc_in,
  input  logic       in_bypass,
  input  logic       in_valid,
  output logic       in_ready,
  output aes_state_t mc_out,
  output logic       out_valid,
  input  logic       out_ready
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter value on the clock that processes column 3.
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  mc_state_t  state;
  aes_state_t data_q;
  aes_state_t next_data;
  logic [1:0] cnt;
  logic       bypass_q;

  logic [1:0] widx [COLS_PER_CYCLE];
  aes_col_t   win  [COLS_PER_CYCLE];
  aes_col_t   wout [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign widx[g] = cnt + 2'(g);
    assign win[g]  = {data_q[3][widx[g]], data_q[2][widx[g]],
                      data_q[1][widx[g]], data_q[0][widx[g]]};

    mix_column_word #(.INVERSE(INVERSE)) u_word (
      .col_in  (win[g]),
      .col_out (wout[g])
    );
  end

  // Working state with the current group of columns replaced in place.
  always_comb begin
    next_data = data_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      for (int r = 0; r < 4; r++) begin
        next_data[r][widx[g]] = wout[g][r];
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mc_out    <= '0;
      cnt       <= '0;
      bypass_q  <= 1'b0;
      // NOTE: the working register is reset too; it is only one state wide
      // and a defined value keeps X out of the datapath after reset.
      data_q    <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data_q   <= mc_in;
            bypass_q <= in_bypass;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (in_bypass) begin
              mc_out    <= mc_in;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          data_q <= next_data;
          // Wraps back to 0 on the final step, ready for the next block.
          cnt    <= cnt + CNT_STEP;
          if (cnt == LAST_CNT) begin
            mc_out    <= next_data;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

  // A bypassed block goes straight to DONE and must never be iterated.
  a_no_bypass_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_BUSY) |-> !bypass_q);

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       sel = 1'b0;      // 0 = forward DUT, 1 = inverse DUT
  logic       dvalid = 1'b0;
  logic       dbyp = 1'b0;
  logic       ordy = 1'b1;
  logic       zero = 1'b0;
  logic       one = 1'b1;
  aes_state_t din = '0;

  logic       f_ir, f_ov, i_ir, i_ov;
  aes_state_t f_out, i_out;
  logic       m_ir, m_ov;
  aes_state_t m_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.INVERSE(1'b0), .COLS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mc_in(din), .in_bypass(dbyp),
    .in_valid(dvalid & ~sel), .in_ready(f_ir), .mc_out(f_out),
    .out_valid(f_ov), .out_ready(ordy)
  );

  mix_columns_seq #(.INVERSE(1'b1), .COLS_PER_CYCLE(1)) dui (
    .clk(clk), .rst_n(rst_n), .flush(zero), .mc_in(din), .in_bypass(dbyp),
    .in_valid(dvalid & sel), .in_ready(i_ir), .mc_out(i_out),
    .out_valid(i_ov), .out_ready(ordy)
  );

  assign m_ir  = sel ? i_ir  : f_ir;
  assign m_ov  = sel ? i_ov  : f_ov;
  assign m_out = sel ? i_out : f_out;

  // Forward -> inverse chains at 1, 2 and 4 columns per clock.
  logic       c_valid [3];
  aes_state_t c_in    [3];
  logic       c_rdy   [3];
  aes_state_t c_mid   [3];
  logic       c_midv  [3];
  logic       c_midr  [3];
  aes_state_t c_out   [3];
  logic       c_ov    [3];

  for (genvar i = 0; i < 3; i++) begin : g_chain
    mix_columns_seq #(.INVERSE(1'b0), .COLS_PER_CYCLE(1 << i)) u_f (
      .clk(clk), .rst_n(rst_n), .flush(zero), .mc_in(c_in[i]), .in_bypass(zero),
      .in_valid(c_valid[i]), .in_ready(c_rdy[i]), .mc_out(c_mid[i]),
      .out_valid(c_midv[i]), .out_ready(c_midr[i])
    );
    mix_columns_seq #(.INVERSE(1'b1), .COLS_PER_CYCLE(1 << i)) u_i (
      .clk(clk), .rst_n(rst_n), .flush(zero), .mc_in(c_mid[i]), .in_bypass(zero),
      .in_valid(c_midv[i]), .in_ready(c_midr[i]), .mc_out(c_out[i]),
      .out_valid(c_ov[i]), .out_ready(one)
    );
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: carry-less multiply, then long division by 0x11B.
  function automatic logic [7:0] gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--) if (((p >> i) & 1) == 1) p = p ^ (32'h11B << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix product applied to every column.
  function automatic aes_state_t ref_mix(input aes_state_t s, input logic inv);
    int coef [4];
    int acc;
    aes_state_t o;
    if (inv) coef = '{14, 11, 13, 9};
    else     coef = '{2, 3, 1, 1};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc = acc ^ int'(gmul(int'(s[(r + k) % 4][c]), coef[k]));
        o[r][c] = acc[7:0];
      end
    end
    return o;
  endfunction

  // Builds a state from four columns written {row0,row1,row2,row3}.
  function automatic aes_state_t cols(input logic [31:0] c0, input logic [31:0] c1,
                                      input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] cc [4];
    aes_state_t s;
    cc = '{c0, c1, c2, c3};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = cc[c][31 - 8 * r -: 8];
    return s;
  endfunction

  function automatic aes_state_t rand_state();
    aes_state_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = 8'($urandom);
    return s;
  endfunction

  // Offers one block to the selected DUT; lat counts rising edges after the
  // accept edge until out_valid is seen (0 = visible right after accept).
  task automatic send(input logic use_inv, input aes_state_t d, input logic byp,
                      output aes_state_t got, output int lat);
    int w;
    @(negedge clk);
    sel = use_inv; din = d; dbyp = byp; dvalid = 1'b1;
    #1;
    w = 0;
    while (!m_ir && w < 50) begin @(negedge clk); #1; w++; end
    if (w >= 50) check("in_ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
    dvalid = 1'b0;
    #1;
    lat = 0;
    while (!m_ov && lat < 50) begin @(negedge clk); #1; lat++; end
    got = m_out;
    if (ordy) @(negedge clk);
  endtask

  typedef struct {
    logic       inv;
    logic       byp;
    aes_state_t din;
    aes_state_t exp;
  } vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs [5];
    aes_state_t got, d, exp, held, prev, cnt_pat;
    int         lat, t;
    logic       byp, seen;

    for (int i = 0; i < 3; i++) begin c_valid[i] = 1'b0; c_in[i] = '0; end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) cnt_pat[r][c] = 8'((4 * c + r) * 17);

    vecs[0] = '{1'b0, 1'b0, cols(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345),
                            cols(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc)};
    vecs[1] = '{1'b0, 1'b0, cols(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5),
                            cols(32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6)};
    vecs[2] = '{1'b1, 1'b0, cols(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc),
                            cols(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345)};
    vecs[3] = '{1'b0, 1'b1, cnt_pat, cnt_pat};
    vecs[4] = '{1'b1, 1'b1, cnt_pat, cnt_pat};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", f_ir, 1'b1);
    check("rst_out_valid", f_ov, 1'b0);
    check("rst_mc_out", f_out, '0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].inv, vecs[i].din, vecs[i].byp, got, lat);
      check($sformatf("vec%0d_data", i), got, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 128'(lat), vecs[i].byp ? 128'd0 : 128'd4);
    end

    // Random blocks against the model, both directions, some bypassed
    for (int n = 0; n < 60; n++) begin
      d   = rand_state();
      byp = ($urandom_range(0, 3) == 0);
      exp = byp ? d : ref_mix(d, n >= 40);
      send(n >= 40, d, byp, got, lat);
      check("rand_data", got, exp);
      check("rand_lat", 128'(lat), byp ? 128'd0 : 128'd4);
    end

    // Backpressure in DONE
    ordy = 1'b0;
    d = rand_state();
    send(1'b0, d, 1'b0, held, lat);
    check("bp_data", held, ref_mix(d, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sel = 1'b0; din = rand_state(); dvalid = 1'b1;
      #1;
      check("bp_out_valid", f_ov, 1'b1);
      check("bp_mc_out", f_out, held);
      check("bp_in_ready", f_ir, 1'b0);
    end
    @(negedge clk);
    dvalid = 1'b0; ordy = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_valid", f_ov, 1'b0);
    check("bp_release_ready", f_ir, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("bp_idle_valid", f_ov, 1'b0);
    check("bp_idle_ready", f_ir, 1'b1);

    // Flush on the second BUSY clock
    prev = f_out;
    @(negedge clk);
    sel = 1'b0; dbyp = 1'b0; din = rand_state(); dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); #1; if (f_ov) seen = 1'b1; end
    check("flush_no_valid", seen, 1'b0);
    check("flush_in_ready", f_ir, 1'b1);
    check("flush_mc_out_hold", f_out, prev);
    send(1'b0, cols(32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c), 1'b0, got, lat);
    check("after_flush_data",
          got, cols(32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8));

    // Flush together with in_valid: nothing captured
    @(negedge clk);
    sel = 1'b0; din = rand_state(); dvalid = 1'b1; flush = 1'b1;
    @(negedge clk);
    dvalid = 1'b0; flush = 1'b0;
    #1;
    check("flush_vs_valid_ready", f_ir, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); #1; if (f_ov) seen = 1'b1; end
    check("flush_vs_valid_no_out", seen, 1'b0);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    sel = 1'b0; din = rand_state(); dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", f_ir, 1'b1);
    check("arst_out_valid", f_ov, 1'b0);
    check("arst_mc_out", f_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); #1; if (f_ov) seen = 1'b1; end
    check("arst_no_partial", seen, 1'b0);

    // Forward then inverse returns the input, at every width
    for (int w = 0; w < 3; w++) begin
      for (int n = 0; n < 100; n++) begin
        d = rand_state();
        @(negedge clk);
        c_in[w] = d; c_valid[w] = 1'b1;
        #1;
        t = 0;
        while (!c_rdy[w] && t < 50) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        c_valid[w] = 1'b0;
        #1;
        t = 0;
        while (!c_ov[w] && t < 50) begin @(negedge clk); #1; t++; end
        check($sformatf("chain_w%0d", 1 << w), c_out[w], d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
